rv32i_decode_regs: RTL and testbench

//  RV32I decode stage with an integrated 32x32 register file (x0 hardwired to 0).

---
 rtl/rv32i_decode_regs_if.sv | 35 +++
 rtl/rv32i_decode_regs.sv | 202 ++++++++++++++++++++
 tb/tb_rv32i_decode_regs.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/rv32i_decode_regs_if.sv
// Fetch/writeback-to-decode bundle and decode-to-execute results for rv32i_decode_regs.
interface rv32i_decode_regs_if;
    logic [31:0] instr;
    logic        w_en;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        is_load;
    logic        is_store;
    logic        is_ui;
    logic        add_pc;
    logic        is_branch;
    logic        is_jump;
    logic        is_reg;
    logic        is_alu;
    logic [31:0] operand_a;
    logic [31:0] operand_b;
    logic [31:0] branch_dest;
    logic [4:0]  dest;
    logic [2:0]  func3;
    logic        func7;
    logic [4:0]  raddr1;
    logic [4:0]  raddr2;

    modport master (
        output instr, w_en, waddr, wdata,
        input  is_load, is_store, is_ui, add_pc, is_branch, is_jump, is_reg, is_alu,
        input  operand_a, operand_b, branch_dest, dest, func3, func7, raddr1, raddr2
    );

    modport slave (
        input  instr, w_en, waddr, wdata,
        output is_load, is_store, is_ui, add_pc, is_branch, is_jump, is_reg, is_alu,
        output operand_a, operand_b, branch_dest, dest, func3, func7, raddr1, raddr2
    );
endinterface

// File: rtl/rv32i_decode_regs.sv
// RV32I decode stage: classifies instr, extracts immediates, reads a 32x32 register
// file (x0 = 0) and registers operands/fields for execute one cycle later.
module rv32i_decode_regs (
    input logic             clk,
    input logic             reset,
    rv32i_decode_regs_if.slave bus
);
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    logic [31:0] rf_q [32];

    logic [6:0]  opcode;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [31:0] imm_i, imm_s, imm_b, imm_j, imm_u;
    logic [31:0] rs1_val, rs2_val;

    logic        is_load_d, is_store_d, is_ui_d, add_pc_d;
    logic        is_branch_d, is_jump_d, is_reg_d, is_alu_d;
    logic [31:0] operand_a_d, operand_b_d, branch_dest_d;
    logic [4:0]  dest_d;
    logic [2:0]  func3_d;
    logic        func7_d;

    logic        is_load_q, is_store_q, is_ui_q, add_pc_q;
    logic        is_branch_q, is_jump_q, is_reg_q, is_alu_q;
    logic [31:0] operand_a_q, operand_b_q, branch_dest_q;
    logic [4:0]  dest_q;
    logic [2:0]  func3_q;
    logic        func7_q;

    assign opcode = bus.instr[6:0];
    assign rd     = bus.instr[11:7];
    assign f3     = bus.instr[14:12];
    assign rs1    = bus.instr[19:15];
    assign rs2    = bus.instr[24:20];

    assign imm_i = {{20{bus.instr[31]}}, bus.instr[31:20]};
    assign imm_s = {{20{bus.instr[31]}}, bus.instr[31:25], bus.instr[11:7]};
    assign imm_b = {{19{bus.instr[31]}}, bus.instr[31], bus.instr[7],
                    bus.instr[30:25], bus.instr[11:8], 1'b0};
    assign imm_j = {{11{bus.instr[31]}}, bus.instr[31], bus.instr[19:12],
                    bus.instr[20], bus.instr[30:21], 1'b0};
    assign imm_u = {bus.instr[31:12], 12'b0};

    // Asynchronous reads; no bypass from a same-edge write.
    assign rs1_val = (rs1 == 5'd0) ? 32'd0 : rf_q[rs1];
    assign rs2_val = (rs2 == 5'd0) ? 32'd0 : rf_q[rs2];

    assign bus.raddr1 = reset ? rs1 : 5'd0;
    assign bus.raddr2 = reset ? rs2 : 5'd0;

    always_ff @(posedge clk) begin
        if (bus.w_en && (bus.waddr != 5'd0)) begin
            rf_q[bus.waddr] <= bus.wdata;
        end
    end

    always_comb begin
        is_load_d     = 1'b0;
        is_store_d    = 1'b0;
        is_ui_d       = 1'b0;
        add_pc_d      = 1'b0;
        is_branch_d   = 1'b0;
        is_jump_d     = 1'b0;
        is_reg_d      = 1'b0;
        is_alu_d      = 1'b0;
        operand_a_d   = 32'd0;
        operand_b_d   = 32'd0;
        branch_dest_d = 32'd0;
        dest_d        = 5'd0;
        func3_d       = 3'd0;
        func7_d       = 1'b0;
        case (opcode)
            OPC_JAL: begin
                is_jump_d   = 1'b1;
                operand_a_d = imm_j;
                dest_d      = rd;
            end
            OPC_JALR: begin
                is_jump_d   = 1'b1;
                is_reg_d    = 1'b1;
                operand_a_d = rs1_val;
                operand_b_d = imm_i;
                dest_d      = rd;
                func3_d     = f3;
            end
            OPC_BRANCH: begin
                is_branch_d   = 1'b1;
                operand_a_d   = rs1_val;
                operand_b_d   = rs2_val;
                branch_dest_d = imm_b;
                func3_d       = f3;
            end
            OPC_LOAD: begin
                is_load_d   = 1'b1;
                operand_a_d = rs1_val;
                operand_b_d = imm_i;
                dest_d      = rd;
                func3_d     = f3;
            end
            OPC_STORE: begin
                is_store_d    = 1'b1;
                operand_a_d   = rs1_val;
                operand_b_d   = rs2_val;
                branch_dest_d = imm_s;
                func3_d       = f3;
            end
            OPC_OPIMM: begin
                is_alu_d    = 1'b1;
                operand_a_d = rs1_val;
                dest_d      = rd;
                func3_d     = f3;
                // Shifts carry shamt in the immediate and the arith/logical bit in instr[30].
                if (f3 == 3'b001 || f3 == 3'b101) begin
                    operand_b_d = {27'd0, bus.instr[24:20]};
                    func7_d     = bus.instr[30];
                end else begin
                    operand_b_d = imm_i;
                end
            end
            OPC_OP: begin
                is_alu_d    = 1'b1;
                operand_a_d = rs1_val;
                operand_b_d = rs2_val;
                dest_d      = rd;
                func3_d     = f3;
                func7_d     = bus.instr[30];
            end
            OPC_LUI: begin
                is_ui_d     = 1'b1;
                operand_a_d = imm_u;
                dest_d      = rd;
            end
            OPC_AUIPC: begin
                is_ui_d     = 1'b1;
                add_pc_d    = 1'b1;
                operand_a_d = imm_u;
                dest_d      = rd;
            end
            default: ;
        endcase
    end

    // Decode -> execute register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            is_load_q     <= 1'b0;
            is_store_q    <= 1'b0;
            is_ui_q       <= 1'b0;
            add_pc_q      <= 1'b0;
            is_branch_q   <= 1'b0;
            is_jump_q     <= 1'b0;
            is_reg_q      <= 1'b0;
            is_alu_q      <= 1'b0;
            operand_a_q   <= 32'd0;
            operand_b_q   <= 32'd0;
            branch_dest_q <= 32'd0;
            dest_q        <= 5'd0;
            func3_q       <= 3'd0;
            func7_q       <= 1'b0;
        end else begin
            is_load_q     <= is_load_d;
            is_store_q    <= is_store_d;
            is_ui_q       <= is_ui_d;
            add_pc_q      <= add_pc_d;
            is_branch_q   <= is_branch_d;
            is_jump_q     <= is_jump_d;
            is_reg_q      <= is_reg_d;
            is_alu_q      <= is_alu_d;
            operand_a_q   <= operand_a_d;
            operand_b_q   <= operand_b_d;
            branch_dest_q <= branch_dest_d;
            dest_q        <= dest_d;
            func3_q       <= func3_d;
            func7_q       <= func7_d;
        end
    end

    assign bus.is_load     = is_load_q;
    assign bus.is_store    = is_store_q;
    assign bus.is_ui       = is_ui_q;
    assign bus.add_pc      = add_pc_q;
    assign bus.is_branch   = is_branch_q;
    assign bus.is_jump     = is_jump_q;
    assign bus.is_reg      = is_reg_q;
    assign bus.is_alu      = is_alu_q;
    assign bus.operand_a   = operand_a_q;
    assign bus.operand_b   = operand_b_q;
    assign bus.branch_dest = branch_dest_q;
    assign bus.dest        = dest_q;
    assign bus.func3       = func3_q;
    assign bus.func7       = func7_q;
endmodule

// File: tb/tb_rv32i_decode_regs.sv
// Directed bench for rv32i_decode_regs with hand-computed expectations.
module tb_rv32i_decode_regs;
    logic clk;
    logic reset;
    int   total;
    int   bad;

    rv32i_decode_regs_if bus ();

    rv32i_decode_regs dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Flag order: load, store, ui, add_pc, branch, jump, reg, alu
    localparam logic [7:0] F_NONE   = 8'h00;
    localparam logic [7:0] F_LOAD   = 8'h80;
    localparam logic [7:0] F_STORE  = 8'h40;
    localparam logic [7:0] F_LUI    = 8'h20;
    localparam logic [7:0] F_AUIPC  = 8'h30;
    localparam logic [7:0] F_BRANCH = 8'h08;
    localparam logic [7:0] F_JAL    = 8'h04;
    localparam logic [7:0] F_JALR   = 8'h06;
    localparam logic [7:0] F_ALU    = 8'h01;

    function automatic logic [7:0] flags();
        return {bus.is_load, bus.is_store, bus.is_ui, bus.add_pc,
                bus.is_branch, bus.is_jump, bus.is_reg, bus.is_alu};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        bus.w_en  = 1'b1;
        bus.waddr = a;
        bus.wdata = d;
        tick();
        bus.w_en  = 1'b0;
    endtask

    task automatic exec(input logic [31:0] ins);
        bus.instr = ins;
        tick();
    endtask

    task automatic chk_all(input string tag, input logic [7:0] f, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] bd, input logic [4:0] d,
                           input logic [2:0] f3, input logic f7);
        chk({tag, ".flags"}, {24'd0, flags()}, {24'd0, f});
        chk({tag, ".op_a"}, bus.operand_a, a);
        chk({tag, ".op_b"}, bus.operand_b, b);
        chk({tag, ".bdest"}, bus.branch_dest, bd);
        chk({tag, ".dest"}, {27'd0, bus.dest}, {27'd0, d});
        chk({tag, ".func3"}, {29'd0, bus.func3}, {29'd0, f3});
        chk({tag, ".func7"}, {31'd0, bus.func7}, {31'd0, f7});
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        reset     = 1'b0;
        bus.instr = 32'h015A0EB3;
        bus.w_en  = 1'b0;
        bus.waddr = 5'd0;
        bus.wdata = 32'd0;
        #1;
        chk("rst.raddr1", {27'd0, bus.raddr1}, 32'd0);
        chk("rst.raddr2", {27'd0, bus.raddr2}, 32'd0);
        tick();
        tick();
        chk_all("rst", F_NONE, 32'd0, 32'd0, 32'd0, 5'd0, 3'd0, 1'b0);
        reset = 1'b1;
        #1;
        chk("raddr1", {27'd0, bus.raddr1}, 32'd20);
        chk("raddr2", {27'd0, bus.raddr2}, 32'd21);

        bus.instr = 32'd0;
        wr(5'd31, 32'd12345);
        wr(5'd15, 32'd9876);
        wr(5'd14, 32'd4567);
        wr(5'd5,  32'd10);
        wr(5'd3,  32'd5000);
        wr(5'd20, 32'd900);
        wr(5'd21, 32'd2000);
        wr(5'd6,  32'd111);
        wr(5'd0,  32'hDEADBEEF);

        exec(32'h7D0001EF);
        chk_all("jal", F_JAL, 32'd2000, 32'd0, 32'd0, 5'd3, 3'd0, 1'b0);
        exec(32'h7D0F8167);
        chk_all("jalr", F_JALR, 32'd12345, 32'd2000, 32'd0, 5'd2, 3'd0, 1'b0);
        exec(32'h7CE78863);
        chk_all("beq", F_BRANCH, 32'd9876, 32'd4567, 32'd2000, 5'd0, 3'd0, 1'b0);
        exec(32'h7CE7A823);
        chk_all("sw", F_STORE, 32'd9876, 32'd4567, 32'd2000, 5'd0, 3'd2, 1'b0);
        exec(32'hFFC2A403);
        chk_all("lw", F_LOAD, 32'd10, 32'hFFFFFFFC, 32'd0, 5'd8, 3'd2, 1'b0);
        exec(32'h8302FF93);
        chk_all("andi", F_ALU, 32'd10, 32'hFFFFF830, 32'd0, 5'd31, 3'd7, 1'b0);
        exec(32'h40A1D693);
        chk_all("srai", F_ALU, 32'd5000, 32'd10, 32'd0, 5'd13, 3'd5, 1'b1);
        exec(32'h015A0EB3);
        chk_all("add", F_ALU, 32'd900, 32'd2000, 32'd0, 5'd29, 3'd0, 1'b0);
        exec(32'h000012B7);
        chk_all("lui", F_LUI, 32'd4096, 32'd0, 32'd0, 5'd5, 3'd0, 1'b0);
        exec(32'h00002117);
        chk_all("auipc", F_AUIPC, 32'd8192, 32'd0, 32'd0, 5'd2, 3'd0, 1'b0);
        exec(32'h000000B3);
        chk_all("x0", F_ALU, 32'd0, 32'd0, 32'd0, 5'd1, 3'd0, 1'b0);
        exec(32'hFFFFFFFF);
        chk_all("unk", F_NONE, 32'd0, 32'd0, 32'd0, 5'd0, 3'd0, 1'b0);

        // ADD x7,x6,x6 while x6 is overwritten on the same edge
        bus.instr = 32'h006303B3;
        wr(5'd6, 32'd222);
        chk("nobyp.op_a", bus.operand_a, 32'd111);
        chk("nobyp.op_b", bus.operand_b, 32'd111);
        tick();
        chk("byp.op_a", bus.operand_a, 32'd222);
        chk("byp.dest", {27'd0, bus.dest}, 32'd7);

        #2;
        reset = 1'b0;
        #1;
        chk("arst.op_a", bus.operand_a, 32'd0);
        chk("arst.dest", {27'd0, bus.dest}, 32'd0);
        chk("arst.flags", {24'd0, flags()}, 32'd0);
        chk("arst.raddr1", {27'd0, bus.raddr1}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
